seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Display-side consumer of the Rotator's `display_value`/`dp` output. It latches the 14-bit binary value once per display frame and converts it to four BCD digits with a sequential double-dabble FSM. It then time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display.

Parameters:
- `REFRESH_DIV`, default 100000: clocks per digit slot (1 kHz digit rate, 250 Hz frame at 100 MHz). Legal range is 20 or more.
- `DP_DIGIT`, default 2: digit index (0 = rightmost) whose decimal point lights when the latched `dp` is 1.
- `BLANK_LZ`, default 1: 1 blanks leading zeros in digits 3..1; digit 0 is never blanked.

Ports:
- `clk100Mhz`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `display_value`  in  14  binary value to show; values above 9999 saturate.
- `dp`  in  1  decimal-point request, sampled with `display_value`.
- `an`  out  4  digit anodes, active low, one-hot; `an[0]` is the rightmost digit.
- `seg`  out  7  segments, active low; `seg[0]`=a … `seg[6]`=g.
- `dp_n`  out  1  decimal point, active low.
- `busy`  out  1  high while a BCD conversion is in progress.

Behaviour:
- **Clock and reset:** single clock `clk100Mhz`; `rst` is synchronous, active-high.
- **Reset values:**
  - outputs: `an`=4'b1111, `seg`=7'b1111111, `dp_n`=1, `busy`=0.
  - internal: refresh counter=0, digit index=0, BCD digit registers=0, latched `dp`=0, FSM=IDLE.
- **Reset mid-operation:** any conversion in flight is aborted with no partial digit update; all state returns to reset values.
- **Refresh counter:** counts 0..`REFRESH_DIV`-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- **Conversion request:** asserted on the first clock after `rst` deasserts, and on every 3→0 index wrap (frame start).
- **Latch on request:**
  - `min(display_value, 9999)` goes into a 14-bit shift register; the BCD scratch register (16 bits) is cleared.
  - `dp` is latched.
  - `busy` rises on the next cycle.
- **FSM:**
  - IDLE → SHIFT on request.
  - SHIFT runs exactly 14 cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1.
  - SHIFT → DONE after the 14th shift.
  - DONE lasts one cycle: the scratch register copies atomically into the displayed digit registers, then → IDLE with `busy`=0.
- **Latency:**
  - request to new digits visible in the digit registers: 16 cycles.
  - `busy` is high for 15 cycles (SHIFT + DONE).
- **Overlapping request:** a request arriving while `busy` is ignored. It cannot occur when `REFRESH_DIV` ≥ 20.
- **Mid-frame input changes:** changes to `display_value`/`dp` between requests are not seen until the next frame start.
- **Output timing:** `an`/`seg`/`dp_n` are registered and reflect the current index and digit registers one cycle after an index change.
  - `an` = ~(1 << index).
- **Segment encoding** (g..a, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Leading-zero blanking** (`BLANK_LZ`=1): digit k (k=3..1) shows 1111111 if it and every higher digit are zero. The anode still pulses for a blanked digit.
- **Decimal point:** `dp_n`=0 iff latched `dp`=1 and index==`DP_DIGIT`. The decimal point lights even if that digit is blanked.

Test Plan:
- **Reset:** hold `rst`=1 for 10 cycles with `display_value`=1234 → `an`=1111, `seg`=1111111, `dp_n`=1, `busy`=0 throughout. Assert `rst` mid-SHIFT → same values on the next edge, and a fresh conversion starts after release.
- **Basic scan:** `REFRESH_DIV`=20, `display_value`=1234, `dp`=0 → `busy` high for cycles 2..16 after release. The second frame shows:
  - `an`=1110/`seg`=0011001 (4), `an`=1101/0110000 (3), `an`=1011/0100100 (2), `an`=0111/1111001 (1)
  - `dp_n`=1 always; each digit slot lasts 20 cycles.
- **Blanking and decimal point:** `display_value`=305, `dp`=1 → `an`=0111 shows 1111111, `an`=1011 shows 0110000 with `dp_n`=0, `an`=1101 shows 1000000, `an`=1110 shows 0010010. `dp_n`=1 at the other three anodes.
- **Saturation:** `display_value`=16383 → all four digits show 0010000 (9). `display_value`=10000 → also 9999.
- **Mid-frame change:** switch 1234→5678 while index=1 → the rest of that frame still shows 1234. The next frame shows 8,7,6,5 (0000000, 1111000, 0000010, 0010010).
- **Zero:** `display_value`=0 → digits 3..1 blank, digit 0 shows 1000000.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver: latches a binary value once per frame,
// converts it to BCD with a serial double-dabble FSM and scans the digits onto a common-anode display.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_DIGIT    = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk100Mhz,
  input  logic        rst,
  input  logic [13:0] display_value,
  input  logic        dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_idx;
  logic               r_first;
  logic [13:0]        r_bin;
  logic [15:0]        r_bcd;
  logic [3:0]         r_shcnt;
  logic [15:0]        r_dig;
  logic               r_dp;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dpn;

  logic               w_tc;
  logic               w_req;
  logic [13:0]        w_sat;
  logic [15:0]        w_bcd_adj;
  logic [3:0]         w_digit;
  logic [3:0]         w_lz;
  logic               w_blank;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_tc      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  // A conversion starts on the first cycle out of reset and at every frame start (3 -> 0 wrap).
  assign w_req     = r_first | (w_tc & (r_idx == 2'd3));
  assign w_sat     = (display_value > 14'd9999) ? 14'd9999 : display_value;
  assign w_bcd_adj = bcd_adjust(r_bcd);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_shcnt == 4'd13) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100Mhz) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Refresh timing and conversion datapath
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_first <= 1'b1;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_shcnt <= '0;
      r_dig   <= '0;
      r_dp    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: if (w_req) begin
          r_bin   <= w_sat;
          r_bcd   <= '0;
          r_dp    <= dp;
          r_shcnt <= '0;
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_shcnt        <= r_shcnt + 4'd1;
        end
        S_DONE:  r_dig <= r_bcd;
        default: ;
      endcase
    end
  end

  // A digit blanks when it and every digit to its left are zero; digit 0 never blanks.
  assign w_lz[3] = (r_dig[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] & (r_dig[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] & (r_dig[7:4] == 4'd0);
  assign w_lz[0] = 1'b0;
  assign w_digit = r_dig[4*r_idx +: 4];
  assign w_blank = (BLANK_LZ != 0) && w_lz[r_idx];

  // Registered display outputs
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dpn <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'b1111111 : seg_encode(w_digit);
      r_dpn <= ~(r_dp && (r_idx == 2'(DP_DIGIT)));
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp_n = r_dpn;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner: a cycle-level reference model derives the expected
// anode, segment, decimal-point and busy values from frame timing and decimal arithmetic.
module tb_seven_seg_scanner;
  localparam int DIV   = 20;
  localparam int DPD   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] val = 14'd0;
  logic        dpi = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, value shown, pending conversion
  int t        = 0;
  int shown    = 0;
  int pend_val = 0;
  int pend_t   = 0;
  bit pend_act = 1'b0;
  bit dpl      = 1'b0;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .DP_DIGIT(DPD), .BLANK_LZ(1)) dut (
    .clk100Mhz     (clk),
    .rst           (rst),
    .display_value (val),
    .dp            (dpi),
    .an            (an),
    .seg           (seg),
    .dp_n          (dp_n),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic step();
    int         idx, p10;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn, e_busy;
    @(posedge clk);
    #1;
    if (rst) begin
      t = 0; shown = 0; pend_act = 1'b0; dpl = 1'b0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_dpn = 1'b1; e_busy = 1'b0;
    end else begin
      t++;
      idx   = ((t - 1) / DIV) % 4;
      p10   = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
      e_an  = ~(4'b0001 << idx);
      e_seg = (idx > 0 && shown < p10) ? 7'b1111111 : enc((shown / p10) % 10);
      e_dpn = !(dpl && idx == DPD);
      if (pend_act && t == pend_t + 15) begin
        shown    = pend_val;
        pend_act = 1'b0;
      end
      if (t == 1 || (t % FRAME) == 0) begin
        pend_val = (int'(val) > 9999) ? 9999 : int'(val);
        pend_t   = t;
        pend_act = 1'b1;
        dpl      = dpi;
      end
      e_busy = pend_act && (t <= pend_t + 14);
    end
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dpn));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; val = 14'd1234; dpi = 1'b0;
    run(10);

    rst = 1'b0;
    run(3 * FRAME);

    val = 14'd305; dpi = 1'b1;
    run(2 * FRAME);

    val = 14'd16383; dpi = 1'b0;
    run(2 * FRAME);
    val = 14'd10000;
    run(2 * FRAME);
    val = 14'd0;
    run(2 * FRAME);

    // Switch value in the middle of a frame, while digit 1 is being scanned
    val = 14'd1234;
    run(2 * FRAME);
    for (int i = 0; i < FRAME && ((t / DIV) % 4) != 1; i++) step();
    val = 14'd5678;
    run(2 * FRAME);

    // Reset while a conversion is shifting
    for (int i = 0; i < FRAME && (t % FRAME) != 5; i++) step();
    rst = 1'b1;
    run(2);
    rst = 1'b0; val = 14'd4321; dpi = 1'b1;
    run(2 * FRAME + 20);

    repeat (25) begin
      case ($urandom_range(0, 5))
        0:       val = 14'd0;
        1:       val = 14'd9999;
        2:       val = 14'd10000;
        3:       val = 14'd16383;
        default: val = 14'($urandom_range(0, 16383));
      endcase
      dpi = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      run($urandom_range(1, 200));
    end
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
